lsys_axiom_streamer: RTL

- Sits directly downstream of the axiom PIO output register. Its 32-bit out_port drives axiom_in here.
- On a start pulse it latches the packed axiom word, a string of 4-bit turtle/grammar symbols.
- It emits the symbols one per handshake, LSB nibble first, to the L-system expansion engine.
- The stream ends at the end marker or after NUM_SYM symbols. Completion is flagged with a one-cycle done pulse and a symbol count.

---
 rtl/lsys_axiom_streamer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/lsys_axiom_streamer.sv
// Streams the symbols of a latched packed L-system axiom word, LSB symbol first, over a valid/ready handshake.
// Latency: start to first valid is 1 cycle, last transfer to done is 1 cycle. Data and last hold stable while ready is low.
module lsys_axiom_streamer #(
    parameter int               SYM_W   = 4,
    parameter int               NUM_SYM = 8,
    parameter logic [SYM_W-1:0] END_SYM = 4'hF
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [SYM_W*NUM_SYM-1:0]       axiom_in,
    input  logic                           start,
    input  logic                           abort,
    output logic [SYM_W-1:0]               sym_data,
    output logic                           sym_valid,
    input  logic                           sym_ready,
    output logic                           sym_last,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(NUM_SYM+1)-1:0]   sym_count
);

    localparam int                AX_W     = SYM_W * NUM_SYM;
    localparam int                CNT_W    = $clog2(NUM_SYM + 1);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(NUM_SYM - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [AX_W-1:0]   shift;
    logic [CNT_W-1:0]  index;
    logic [CNT_W-1:0]  count;
    logic              valid_q;
    logic              last_q;
    logic              busy_q;
    logic              done_q;

    logic [AX_W-1:0]   shift_nxt;
    logic [CNT_W-1:0]  idx_nxt;
    logic [CNT_W-1:0]  count_inc;
    logic              last_nxt;
    logic              first_is_end;
    logic              first_last;
    logic              xfer;

    always_comb begin
        shift_nxt    = shift >> SYM_W;
        idx_nxt      = index + CNT_W'(1);
        count_inc    = count + CNT_W'(1);
        // Next symbol is final if it is the last slot or its successor is the terminator.
        last_nxt     = (idx_nxt == LAST_IDX) ||
                       (shift_nxt[2*SYM_W-1:SYM_W] == END_SYM);
        first_is_end = (axiom_in[SYM_W-1:0] == END_SYM);
        first_last   = (LAST_IDX == '0) ||
                       (axiom_in[2*SYM_W-1:SYM_W] == END_SYM);
        xfer         = valid_q && sym_ready;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            shift   <= '0;
            index   <= '0;
            count   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        shift <= axiom_in;
                        index <= '0;
                        count <= '0;
                        if (first_is_end) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state   <= EMIT;
                            valid_q <= 1'b1;
                            busy_q  <= 1'b1;
                            last_q  <= first_last;
                        end
                    end
                end
                EMIT: begin
                    if (xfer) begin
                        count <= count_inc;
                    end
                    // Abort wins over everything, but a coincident transfer is still counted.
                    if (abort) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        last_q  <= 1'b0;
                    end else if (xfer) begin
                        if (last_q) begin
                            state   <= DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            last_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            shift  <= shift_nxt;
                            index  <= idx_nxt;
                            last_q <= last_nxt;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    last_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sym_data  = shift[SYM_W-1:0];
    assign sym_valid = valid_q;
    assign sym_last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign sym_count = count;

endmodule
